// File: rtl/i2c_host_interface.sv
// Port-bus glue between the TramelBlaze, the board switches/fire button and the I2C master core.
// Debounces the fire button into an interrupt and maps I2C address/data/start onto write ports.
module i2c_host_interface #(
  parameter int unsigned DB_COUNT = 3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bt_fire_i,
  input  logic [6:0]  sw_addr_i,
  input  logic [7:0]  sw_data_i,
  input  logic        i2c_ready_i,
  output logic [6:0]  i2c_address_o,
  output logic [7:0]  i2c_data_o,
  output logic        i2c_start_o,
  input  logic [15:0] tb_port_id_i,
  input  logic [15:0] tb_data_i,
  input  logic        tb_write_st_i,
  input  logic        tb_read_st_i,
  input  logic        tb_intr_ack_i,
  output logic        tb_intr_r_o,
  output logic [15:0] tb_data_o
);

  localparam int unsigned CW = (DB_COUNT > 32'd1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_COUNT - 32'd1);

  localparam logic [15:0] PORT_ADDR   = 16'h0001;
  localparam logic [15:0] PORT_DATA   = 16'h0002;
  localparam logic [15:0] PORT_START  = 16'h0003;
  localparam logic [15:0] PORT_STATUS = 16'h0004;
  localparam logic [15:0] PORT_SWADDR = 16'h0005;
  localparam logic [15:0] PORT_SWDATA = 16'h0006;

  logic          sync1_r;
  logic          sync2_r;
  logic [CW-1:0] db_cnt_r;
  logic          db_level_r;
  logic          db_prev_r;
  logic          fire_pulse_s;
  logic          intr_r;
  logic [6:0]    addr_r;
  logic [7:0]    data_r;
  logic          start_r;
  logic [15:0]   rd_data_s;
  logic          unused_s;

  // Read strobe has no side effects and only the low data bits are ever stored.
  assign unused_s = ^{tb_read_st_i, tb_data_i[15:8]};

  // Two-flop synchronizer for the asynchronous button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bt_fire_i;
      sync2_r <= sync1_r;
    end
  end

  // The level only follows the input after it has differed for DB_COUNT consecutive cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_cnt_r   <= {CW{1'b0}};
      db_level_r <= 1'b0;
    end else if (sync2_r == db_level_r) begin
      db_cnt_r   <= {CW{1'b0}};
      db_level_r <= db_level_r;
    end else if (db_cnt_r == CNT_MAX) begin
      db_cnt_r   <= {CW{1'b0}};
      db_level_r <= sync2_r;
    end else begin
      db_cnt_r   <= db_cnt_r + {{(CW-1){1'b0}}, 1'b1};
      db_level_r <= db_level_r;
    end
  end

  // Edge flop for the press detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_prev_r <= 1'b0;
    end else begin
      db_prev_r <= db_level_r;
    end
  end

  assign fire_pulse_s = db_level_r & ~db_prev_r;

  // A press coinciding with an ack must not be lost, so set takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      intr_r <= 1'b0;
    end else if (fire_pulse_s) begin
      intr_r <= 1'b1;
    end else if (tb_intr_ack_i) begin
      intr_r <= 1'b0;
    end else begin
      intr_r <= intr_r;
    end
  end

  // Write-port decode; start is a per-cycle pulse that follows the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= 7'h00;
      data_r  <= 8'h00;
      start_r <= 1'b0;
    end else begin
      start_r <= 1'b0;
      if (tb_write_st_i) begin
        case (tb_port_id_i)
          PORT_ADDR:  addr_r  <= tb_data_i[6:0];
          PORT_DATA:  data_r  <= tb_data_i[7:0];
          PORT_START: start_r <= 1'b1;
          default:    addr_r  <= addr_r;
        endcase
      end else begin
        addr_r <= addr_r;
      end
    end
  end

  // Combinational read mux; unmapped ports read as zero.
  always_comb begin
    rd_data_s = 16'h0000;
    case (tb_port_id_i)
      PORT_STATUS: rd_data_s = {15'h0000, i2c_ready_i};
      PORT_SWADDR: rd_data_s = {9'h000, sw_addr_i};
      PORT_SWDATA: rd_data_s = {8'h00, sw_data_i};
      default:     rd_data_s = 16'h0000;
    endcase
  end

  assign i2c_address_o = addr_r;
  assign i2c_data_o    = data_r;
  assign i2c_start_o   = start_r;
  assign tb_intr_r_o   = intr_r;
  assign tb_data_o     = rd_data_s;

endmodule

// File: tb/tb_i2c_host_interface.sv
// Self-checking bench for i2c_host_interface: table-driven port-bus vectors plus
// hand-written debounce/interrupt sequences with DB_COUNT shortened to 16.
module tb_i2c_host_interface;

  localparam int unsigned DBC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        bt_fire_i = 1'b0;
  logic [6:0]  sw_addr_i = 7'h72;
  logic [7:0]  sw_data_i = 8'hAB;
  logic        i2c_ready_i = 1'b1;
  logic [6:0]  i2c_address_o;
  logic [7:0]  i2c_data_o;
  logic        i2c_start_o;
  logic [15:0] tb_port_id_i = 16'h0000;
  logic [15:0] tb_data_i = 16'h0000;
  logic        tb_write_st_i = 1'b0;
  logic        tb_read_st_i = 1'b0;
  logic        tb_intr_ack_i = 1'b0;
  logic        tb_intr_r_o;
  logic [15:0] tb_data_o;

  int n_cmp = 0;
  int n_err = 0;

  i2c_host_interface #(.DB_COUNT(DBC)) dut (
    .clk           (clk),
    .rst           (rst),
    .bt_fire_i     (bt_fire_i),
    .sw_addr_i     (sw_addr_i),
    .sw_data_i     (sw_data_i),
    .i2c_ready_i   (i2c_ready_i),
    .i2c_address_o (i2c_address_o),
    .i2c_data_o    (i2c_data_o),
    .i2c_start_o   (i2c_start_o),
    .tb_port_id_i  (tb_port_id_i),
    .tb_data_i     (tb_data_i),
    .tb_write_st_i (tb_write_st_i),
    .tb_read_st_i  (tb_read_st_i),
    .tb_intr_ack_i (tb_intr_ack_i),
    .tb_intr_r_o   (tb_intr_r_o),
    .tb_data_o     (tb_data_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [15:0] port;
    logic [15:0] data;
    logic        ready;
    logic [15:0] exp_rd;
    logic [6:0]  exp_addr;
    logic [7:0]  exp_data;
    logic        exp_start;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_intr(input string name, input int budget);
    int k;
    k = 0;
    while (tb_intr_r_o !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check(name, {15'h0000, tb_intr_r_o}, 16'h0001);
  endtask

  task automatic expect_no_intr(input string name, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (tb_intr_r_o !== 1'b0) seen = 1'b1;
    end
    check(name, {15'h0000, seen}, 16'h0000);
  endtask

  initial begin
    //              wr    port      data      rdy   exp_rd    addr   data   start
    vecs[0]  = '{1'b0, 16'h0004, 16'h0000, 1'b1, 16'h0001, 7'h00, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 16'h0005, 16'h0000, 1'b1, 16'h0072, 7'h00, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 16'h0006, 16'h0000, 1'b1, 16'h00AB, 7'h00, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 7'h00, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 16'h0001, 16'h0033, 1'b1, 16'h0000, 7'h33, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 16'h0002, 16'h0044, 1'b1, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[6]  = '{1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[7]  = '{1'b1, 16'h0003, 16'hFFFF, 1'b1, 16'h0000, 7'h33, 8'h44, 1'b1};
    vecs[8]  = '{1'b0, 16'h0003, 16'h0000, 1'b1, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[9]  = '{1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[10] = '{1'b1, 16'h0101, 16'h0077, 1'b0, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[11] = '{1'b1, 16'h8002, 16'h0099, 1'b0, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[12] = '{1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0000, 7'h33, 8'h44, 1'b1};
    vecs[13] = '{1'b1, 16'h0003, 16'h0000, 1'b0, 16'h0000, 7'h33, 8'h44, 1'b1};
    vecs[14] = '{1'b0, 16'h0104, 16'h0000, 1'b1, 16'h0000, 7'h33, 8'h44, 1'b0};
    vecs[15] = '{1'b1, 16'h0001, 16'h01F5, 1'b1, 16'h0000, 7'h75, 8'h44, 1'b0};
    vecs[16] = '{1'b1, 16'h0002, 16'h12CD, 1'b1, 16'h0000, 7'h75, 8'hCD, 1'b0};
    vecs[17] = '{1'b0, 16'h0007, 16'h0000, 1'b1, 16'h0000, 7'h75, 8'hCD, 1'b0};

    rst = 1'b1;
    repeat (3) tick();
    check("reset_addr",  {9'h000, i2c_address_o}, 16'h0000);
    check("reset_data",  {8'h00, i2c_data_o}, 16'h0000);
    check("reset_start", {15'h0000, i2c_start_o}, 16'h0000);
    check("reset_intr",  {15'h0000, tb_intr_r_o}, 16'h0000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 18; i++) begin
      tb_write_st_i = vecs[i].wr;
      tb_port_id_i  = vecs[i].port;
      tb_data_i     = vecs[i].data;
      i2c_ready_i   = vecs[i].ready;
      tb_read_st_i  = ~vecs[i].wr;
      tick();
      check($sformatf("vec%0d_rd", i),    tb_data_o, vecs[i].exp_rd);
      check($sformatf("vec%0d_addr", i),  {9'h000, i2c_address_o}, {9'h000, vecs[i].exp_addr});
      check($sformatf("vec%0d_data", i),  {8'h00, i2c_data_o}, {8'h00, vecs[i].exp_data});
      check($sformatf("vec%0d_start", i), {15'h0000, i2c_start_o}, {15'h0000, vecs[i].exp_start});
    end
    tb_write_st_i = 1'b0;
    tb_read_st_i  = 1'b0;
    tb_port_id_i  = 16'h0000;

    // Valid press: one interrupt, held until ack, no re-trigger while held or on release.
    bt_fire_i = 1'b1;
    wait_intr("press_intr", DBC + 10);
    repeat (8) tick();
    check("intr_held", {15'h0000, tb_intr_r_o}, 16'h0001);
    tb_intr_ack_i = 1'b1;
    tick();
    tb_intr_ack_i = 1'b0;
    check("intr_ack_clear", {15'h0000, tb_intr_r_o}, 16'h0000);
    expect_no_intr("no_repeat_while_held", 2 * DBC);
    bt_fire_i = 1'b0;
    expect_no_intr("no_intr_on_release", 2 * DBC);

    // Bounce: 5-cycle highs separated by 5-cycle lows never debounce.
    for (int b = 0; b < 6; b++) begin
      bt_fire_i = 1'b1;
      repeat (5) tick();
      bt_fire_i = 1'b0;
      repeat (5) tick();
    end
    expect_no_intr("bounce_no_intr", 2 * DBC);

    // Ack landing in the same cycle as a new press pulse: set must win.
    bt_fire_i = 1'b1;
    wait_intr("press2_intr", DBC + 10);
    bt_fire_i = 1'b0;
    repeat (2 * DBC) tick();
    check("intr_still_pending", {15'h0000, tb_intr_r_o}, 16'h0001);
    bt_fire_i = 1'b1;
    repeat (DBC + 2) @(posedge clk);
    #1;
    tb_intr_ack_i = 1'b1;
    tick();
    tb_intr_ack_i = 1'b0;
    check("ack_vs_pulse_set_wins", {15'h0000, tb_intr_r_o}, 16'h0001);
    tb_intr_ack_i = 1'b1;
    tick();
    tb_intr_ack_i = 1'b0;
    check("ack_after_coincide", {15'h0000, tb_intr_r_o}, 16'h0000);
    bt_fire_i = 1'b0;
    repeat (2 * DBC) tick();

    // Reset mid-debounce discards the pending count.
    bt_fire_i = 1'b1;
    repeat (10) tick();
    rst = 1'b1;
    bt_fire_i = 1'b0;
    #1;
    check("midrst_addr",  {9'h000, i2c_address_o}, 16'h0000);
    check("midrst_data",  {8'h00, i2c_data_o}, 16'h0000);
    check("midrst_start", {15'h0000, i2c_start_o}, 16'h0000);
    check("midrst_intr",  {15'h0000, tb_intr_r_o}, 16'h0000);
    repeat (2) tick();
    rst = 1'b0;
    expect_no_intr("no_pulse_after_rst", 3 * DBC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
